// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the memory port arbiter and its helpers.
// FSM states and owner codes are plain localparams so legacy code that
// compares raw bit patterns keeps working.
package riscv_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic OWNER_FETCH = 1'b0;
   localparam logic OWNER_DATA  = 1'b1;

   localparam logic [2:0] FUNCT3_WORD = 3'b010;

   // Data wins a collision unless fetch has already waited out a full data burst.
   function automatic logic arb_pick(input logic fetch_req,
                                     input logic data_req,
                                     input logic burst_full);
      return (data_req && !(fetch_req && burst_full)) ? OWNER_DATA : OWNER_FETCH;
   endfunction

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: per-transaction timeout counter. 'start' reloads it to zero,
// 'tick' advances it by one, and 'expired' is high once the count has reached
// TIMEOUT_CYCLES. The counter stops at the limit so it never wraps.
module arb_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic tick,
   output logic expired
);

   localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count;

   assign expired = (count == LIMIT);

   // Reload on start, otherwise count waited cycles up to the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (start) begin
         count <= '0;
      end else if (tick && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-ported unified memory between the
// instruction-fetch path and the load/store path. Requests are sampled only
// in IDLE, the winner owns the memory through GRANT, and DONE returns a
// one-cycle ready pulse (with error on timeout). Every output is a flop.
module memory_port_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int MAX_DATA_BURST = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk_i,
   input  logic              reset_i,

   input  logic              fetch_req_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   output logic              fetch_ready_o,
   output logic [DATA_W-1:0] fetch_rdata_o,

   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   input  logic [2:0]        data_funct3_i,
   output logic              data_ready_o,
   output logic [DATA_W-1:0] data_rdata_o,

   output logic              error_o,

   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [2:0]        mem_funct3_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ready_i
);

   localparam int                 BURST_W   = (MAX_DATA_BURST < 1) ? 1 : $clog2(MAX_DATA_BURST + 1);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

   logic [1:0]         state;
   logic               owner;
   logic [BURST_W-1:0] burst_cnt;

   logic burst_full;
   logic any_req;
   logic grant_now;
   logic grant_owner;
   logic mem_done;
   logic expired;
   logic wd_tick;

   assign burst_full  = (burst_cnt == BURST_MAX);
   assign any_req     = fetch_req_i | data_req_i;
   assign grant_now   = (state == ST_IDLE) && any_req;
   assign grant_owner = arb_pick(fetch_req_i, data_req_i, burst_full);

   // A transaction ends on memory ready or on timeout; ready wins a tie.
   assign mem_done = (state == ST_GRANT) && (mem_ready_i || expired);
   assign wd_tick  = (state == ST_GRANT) && !mem_ready_i;

   arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk_i),
      .rst_n   (reset_i),
      .start   (grant_now),
      .tick    (wd_tick),
      .expired (expired)
   );

   // Sequence IDLE -> GRANT -> DONE -> IDLE and remember who owns the port.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state <= ST_IDLE;
         owner <= OWNER_FETCH;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_now) begin
                  state <= ST_GRANT;
                  owner <= grant_owner;
               end
            end
            ST_GRANT: begin
               if (mem_done) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Count data grants that jumped ahead of a waiting fetch, saturating at the burst limit.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         burst_cnt <= '0;
      end else if (grant_now) begin
         if ((grant_owner == OWNER_DATA) && fetch_req_i) begin
            if (!burst_full) begin
               burst_cnt <= burst_cnt + BURST_W'(1);
            end
         end else begin
            burst_cnt <= '0;
         end
      end
   end

   // Latch the winner's request into the memory-side registers and hold it through GRANT.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         mem_req_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
         mem_funct3_o <= 3'b000;
      end else if (grant_now) begin
         mem_req_o <= 1'b1;
         if (grant_owner == OWNER_DATA) begin
            mem_we_o     <= data_we_i;
            mem_addr_o   <= data_addr_i;
            mem_wdata_o  <= data_wdata_i;
            mem_funct3_o <= data_funct3_i;
         end else begin
            mem_we_o     <= 1'b0;
            mem_addr_o   <= fetch_addr_i;
            mem_wdata_o  <= '0;
            mem_funct3_o <= FUNCT3_WORD;
         end
      end else if (mem_done) begin
         mem_req_o <= 1'b0;
      end
   end

   // Produce the one-cycle completion pulse and read data for the owner in DONE.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         fetch_ready_o <= 1'b0;
         data_ready_o  <= 1'b0;
         error_o       <= 1'b0;
         fetch_rdata_o <= '0;
         data_rdata_o  <= '0;
      end else begin
         fetch_ready_o <= mem_done && (owner == OWNER_FETCH);
         data_ready_o  <= mem_done && (owner == OWNER_DATA);
         error_o       <= mem_done && !mem_ready_i;
         fetch_rdata_o <= (mem_done && (owner == OWNER_FETCH) && mem_ready_i)
                          ? mem_rdata_i : '0;
         data_rdata_o  <= (mem_done && (owner == OWNER_DATA) && mem_ready_i && !mem_we_o)
                          ? mem_rdata_i : '0;
      end
   end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Sequential arbiter that shares one single-ported unified memory between the core's instruction-fetch path and its load/store path. It sits between the program counter/instruction decoder side and the data-access side of the core and the memory macro, serialising requests with a registered request/ready handshake. It provides data-over-fetch priority, a starvation bound for fetch, and a per-transaction timeout watchdog.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MAX_DATA_BURST`, default 4: number of consecutive data grants allowed while a fetch is pending.
- `TIMEOUT_CYCLES`, default 255: number of cycles allowed in GRANT before the transaction is aborted. Legal range 1..65535.
- `clk_i` in 1: the single clock. All state changes on the rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `fetch_req_i` in 1: fetch request, level-sensitive.
- `fetch_addr_i` in ADDR_W: fetch address.
- `fetch_ready_o` out 1: one-cycle completion pulse for fetch.
- `fetch_rdata_o` out DATA_W: instruction word. Valid while `fetch_ready_o` is high.
- `data_req_i` in 1: load/store request, level-sensitive.
- `data_we_i` in 1: 1 = store, 0 = load.
- `data_addr_i` in ADDR_W: load/store address.
- `data_wdata_i` in DATA_W: store data.
- `data_funct3_i` in 3: access size/sign code, passed through to memory.
- `data_ready_o` out 1: one-cycle completion pulse for load/store.
- `data_rdata_o` out DATA_W: load data. Equals 0 for stores.
- `error_o` out 1: one-cycle pulse on timeout. Coincides with the ready pulse of the aborted requester.
- `mem_req_o` out 1: memory request, held until `mem_ready_i`.
- `mem_we_o` out 1: memory write enable.
- `mem_addr_o` out ADDR_W: memory address.
- `mem_wdata_o` out DATA_W: memory write data.
- `mem_funct3_o` out 3: memory access size/sign code.
- `mem_rdata_i` in DATA_W: memory read data.
- `mem_ready_i` in 1: memory completion. Sampled only while `mem_req_o` is high.

## Operation
- **FSM states:** IDLE, GRANT, DONE. State and owner (FETCH/DATA) are registered.
- **IDLE:** requests are sampled only in this state.
  - If only one requester is active, grant it.
  - If both are active, grant DATA unless `burst_cnt == MAX_DATA_BURST`; in that case grant FETCH.
  - On grant: go to GRANT; latch address, write data, we and funct3 into the `mem_*` registers.
  - A fetch grant always drives `mem_we_o = 0` and `mem_funct3_o = 3'b010`.
- **GRANT:** `mem_req_o = 1` and all `mem_*` outputs are held stable.
  - On `mem_ready_i = 1`: capture `mem_rdata_i` and go to DONE.
  - If the timeout counter reaches `TIMEOUT_CYCLES` without ready: go to DONE with the abort flag set and read data forced to 0.
- **DONE:** the owner's `*_ready_o` is high for exactly one cycle; `error_o` is also high if aborted. Always returns to IDLE on the next edge.
  - Requesters must deassert (or change) their request in the cycle they see ready. Requests present during DONE are ignored.
- **Starvation counter `burst_cnt`:**
  - Increments on each DATA grant made while `fetch_req_i` is high.
  - Clears on any FETCH grant, and on a DATA grant made while fetch is idle.
  - Saturates at `MAX_DATA_BURST`.
- **Timeout counter:** width `clog2(TIMEOUT_CYCLES+1)`. Clears on entering GRANT and increments each GRANT cycle without ready. `mem_ready_i` in the same cycle the limit is hit wins: normal completion, no error.
- **Reset (async, `reset_i` low):** state = IDLE, both counters = 0, every output = 0, including `mem_req_o`. A reset mid-transaction discards it; there is no ready pulse and the requester must reissue.

## Timing
- **Minimum latency:** request high in cycle 0 (IDLE) → `mem_req_o` high in cycle 1 → `mem_ready_i` in cycle 1 → ready pulse in cycle 2 → IDLE in cycle 3. The next grant is possible at cycle 3, giving a throughput of 1 transaction per 3 cycles.
- **Memory wait states:** each wait cycle adds one cycle of latency.
- **Output registration:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Timeout:** `error_o` asserts `TIMEOUT_CYCLES + 1` cycles after `mem_req_o` first rises.

## Structure
- Shared package `riscv_pkg` (Verilog header `riscv_defs.vh`) holds:
  - State encodings: IDLE = 2'd0, GRANT = 2'd1, DONE = 2'd2.
  - Owner encoding: FETCH = 1'b0, DATA = 1'b1.
  - Constant `FUNCT3_WORD = 3'b010`.
- One sub-module, `arb_watchdog`: a loadable timeout counter with `start`, `tick` and `expired` signals.
- The FSM and grant logic stay in `memory_port_arbiter`.

## Test plan
- **Single fetch:** `fetch_req_i = 1` with addr 0x10; memory answers in its first GRANT cycle with 0x00500093. Expect `fetch_ready_o` in cycle 2 with that data, `mem_we_o = 0` throughout, and IDLE in cycle 3.
- **Collision:** both requests high in the same cycle, data is a store of 0xDEADBEEF to 0x40. Expect data granted first (`mem_we_o = 1`, `mem_wdata_o = 0xDEADBEEF`), `data_rdata_o = 0`, and fetch granted on the following IDLE.
- **Starvation:** fetch held high while data re-requests every transaction. Expect exactly 4 data grants, then 1 fetch grant, then `burst_cnt` back at 0.
- **Timeout:** `mem_ready_i` tied low on a load. Expect `data_ready_o` and `error_o` together 256 cycles after `mem_req_o` rises, `data_rdata_o = 0`, and a return to IDLE.
- **Ready at the limit:** `mem_ready_i` asserted exactly on the limit cycle. Expect normal completion with no `error_o`.
- **Reset mid-GRANT:** pull `reset_i` low while `mem_req_o = 1`. Expect all outputs 0 immediately, no ready pulse, and a new request accepted normally after reset release.
